hazard_fwd_unit: RTL and testbench

Pipeline hazard and forwarding controller for the 16-bit, 8-register pipelined processor. It consumes the 3-bit destination register chosen in ID by the 3-bit 4:1 destination mux, along with the ID source-register fields. It tracks those fields through internal EX/MEM/WB shadow registers. From them it produces the load-use stall, the branch flush bubble, the 2-bit forwarding selects for the EX operand muxes, and the register-file write address and enable.

---
 rtl/hazard_fwd_unit.sv | 63 ++++++
 tb/tb_hazard_fwd_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use stall, flush bubbles, EX operand forwarding and writeback control
module hazard_fwd_unit #(
    parameter bit ZERO_REG_RO = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_dest,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             id_valid,
    input  logic [2:0]       id_src_a,
    input  logic [2:0]       id_src_b,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [2:0]       wb_dest,
    output logic             wb_wr_en,
    output logic [CNT_W-1:0] stall_cnt
);
    logic       ex_valid, ex_wr_en, ex_is_load, ex_use_a, ex_use_b;
    logic [2:0] ex_dest, ex_src_a, ex_src_b;
    logic       mem_valid, mem_wr_en, mem_is_load;
    logic [2:0] mem_dest;
    logic       wb_valid, wb_wr;
    logic [2:0] wb_d;

    function automatic logic match(input logic v, input logic w, input logic [2:0] d, input logic [2:0] r);
        return v & w & (d == r) & ~(ZERO_REG_RO & (r == 3'd0));
    endfunction

    assign stall = ~rst & id_valid & ex_is_load &
                   ((id_use_a & match(ex_valid, ex_wr_en, ex_dest, id_src_a)) |
                    (id_use_b & match(ex_valid, ex_wr_en, ex_dest, id_src_b)));
    // a load still in MEM has no data yet, so only WB may supply it
    assign fwd_a = rst ? 2'b00 :
                   (ex_use_a & match(mem_valid, mem_wr_en, mem_dest, ex_src_a) & ~mem_is_load) ? 2'b01 :
                   (ex_use_a & match(wb_valid, wb_wr, wb_d, ex_src_a)) ? 2'b10 : 2'b00;
    assign fwd_b = rst ? 2'b00 :
                   (ex_use_b & match(mem_valid, mem_wr_en, mem_dest, ex_src_b) & ~mem_is_load) ? 2'b01 :
                   (ex_use_b & match(wb_valid, wb_wr, wb_d, ex_src_b)) ? 2'b10 : 2'b00;
    assign wb_dest  = wb_d;
    assign wb_wr_en = ~rst & match(wb_valid, wb_wr, wb_d, wb_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            {ex_valid, ex_wr_en, ex_is_load, ex_use_a, ex_use_b, ex_dest, ex_src_a, ex_src_b} <= '0;
            {mem_valid, mem_wr_en, mem_is_load, mem_dest} <= '0;
            {wb_valid, wb_wr, wb_d} <= '0;
            stall_cnt <= '0;
        end else begin
            {wb_valid, wb_wr, wb_d} <= {mem_valid, mem_wr_en, mem_dest};
            {mem_valid, mem_wr_en, mem_is_load, mem_dest} <= {ex_valid, ex_wr_en, ex_is_load, ex_dest};
            {ex_valid, ex_wr_en, ex_is_load, ex_use_a, ex_use_b, ex_dest, ex_src_a, ex_src_b} <= (flush | stall) ? '0 :
                {id_valid, id_wr_en, id_is_load, id_use_a, id_use_b, id_dest, id_src_a, id_src_b};
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed checks of stall, forwarding, flush, r0 handling and counter saturation
module tb_hazard_fwd_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  id_dest = 3'd0, id_src_a = 3'd0, id_src_b = 3'd0;
    logic        id_wr_en = 1'b0, id_is_load = 1'b0, id_valid = 1'b0;
    logic        id_use_a = 1'b0, id_use_b = 1'b0, flush = 1'b0;
    logic        stall0, stall1, wb_wr_en0, wb_wr_en1;
    logic [1:0]  fwd_a0, fwd_b0, fwd_a1, fwd_b1;
    logic [2:0]  wb_dest0, wb_dest1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.ZERO_REG_RO(1'b1), .CNT_W(16)) d0 (
        .clk(clk), .rst(rst), .id_dest(id_dest), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_a(id_use_a),
        .id_use_b(id_use_b), .flush(flush), .stall(stall0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
        .wb_dest(wb_dest0), .wb_wr_en(wb_wr_en0), .stall_cnt(cnt0)
    );

    hazard_fwd_unit #(.ZERO_REG_RO(1'b0), .CNT_W(4)) d1 (
        .clk(clk), .rst(rst), .id_dest(id_dest), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_a(id_use_a),
        .id_use_b(id_use_b), .flush(flush), .stall(stall1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
        .wb_dest(wb_dest1), .wb_wr_en(wb_wr_en1), .stall_cnt(cnt1)
    );

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (fwd_a0 != 2'b11 && fwd_b0 != 2'b11 &&
                    !(d0.mem_is_load && (fwd_a0 == 2'b01 || fwd_b0 == 2'b01))) else begin
                errors++;
                $display("FAIL fwd_invariant: fwd_a=%b fwd_b=%b mem_is_load=%b required no 11 and no 01 from a load",
                         fwd_a0, fwd_b0, d0.mem_is_load);
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] d, input logic w, input logic ld,
                          input logic [2:0] a, input logic [2:0] b, input logic ua, input logic ub);
        id_valid = v; id_dest = d; id_wr_en = w; id_is_load = ld;
        id_src_a = a; id_src_b = b; id_use_a = ua; id_use_b = ub;
    endtask

    task automatic idle;
        set_id(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset;
        rst = 1'b1; flush = 1'b0; idle();
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 1'b1);
        cyc(); cyc();
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall0); end
        checks++; if ({fwd_a0, fwd_b0} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b expected 0000", {fwd_a0, fwd_b0}); end
        checks++; if (wb_wr_en0 !== 1'b0 || wb_dest0 !== 3'd0) begin errors++; $display("FAIL reset_wb: got en=%b dest=%0d expected 0/0", wb_wr_en0, wb_dest0); end
        checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt0); end
        rst = 1'b0; idle();
    endtask

    task automatic test_back_to_back;
        do_reset();
        set_id(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 3'd6, 1'b1, 1'b0, 3'd3, 3'd1, 1'b1, 1'b1);
        #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL b2b_nostall: got %b expected 0", stall0); end
        cyc(); idle(); #1;
        checks++; if (fwd_a0 !== 2'b01) begin errors++; $display("FAIL b2b_fwd_a: got %b expected 01", fwd_a0); end
        checks++; if (fwd_b0 !== 2'b00) begin errors++; $display("FAIL b2b_fwd_b: got %b expected 00", fwd_b0); end
        cyc();
        checks++; if (wb_dest0 !== 3'd3 || wb_wr_en0 !== 1'b1) begin errors++; $display("FAIL b2b_wb: got dest=%0d en=%b expected 3/1", wb_dest0, wb_wr_en0); end
    endtask

    task automatic test_distance2(input logic i2_writes, input logic [1:0] exp_b);
        do_reset();
        set_id(1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 3'd5, i2_writes, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 3'd7, 1'b1, 1'b0, 3'd1, 3'd5, 1'b0, 1'b1);
        cyc(); idle(); #1;
        checks++; if (fwd_b0 !== exp_b) begin errors++; $display("FAIL dist2_fwd_b(i2w=%b): got %b expected %b", i2_writes, fwd_b0, exp_b); end
        checks++; if (fwd_a0 !== 2'b00) begin errors++; $display("FAIL dist2_fwd_a: got %b expected 00", fwd_a0); end
    endtask

    task automatic test_load_use;
        do_reset();
        set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 3'd7, 1'b1, 1'b0, 3'd2, 3'd4, 1'b1, 1'b1);
        #1;
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall0); end
        cyc();
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %b expected 0", stall0); end
        checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", cnt0); end
        cyc(); idle(); #1;
        checks++; if (fwd_a0 !== 2'b10) begin errors++; $display("FAIL lu_fwd_a: got %b expected 10", fwd_a0); end
        checks++; if (wb_dest0 !== 3'd2 || wb_wr_en0 !== 1'b1) begin errors++; $display("FAIL lu_load_wb: got dest=%0d en=%b expected 2/1", wb_dest0, wb_wr_en0); end
        cyc();
        checks++; if (wb_wr_en0 !== 1'b0) begin errors++; $display("FAIL lu_bubble_wb: got %b expected 0", wb_wr_en0); end
        cyc();
        checks++; if (wb_dest0 !== 3'd7 || wb_wr_en0 !== 1'b1) begin errors++; $display("FAIL lu_add_wb: got dest=%0d en=%b expected 7/1", wb_dest0, wb_wr_en0); end
    endtask

    task automatic test_reg0;
        do_reset();
        set_id(1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        cyc(); idle(); #1;
        checks++; if (fwd_a0 !== 2'b00) begin errors++; $display("FAIL r0_ro_fwd: got %b expected 00", fwd_a0); end
        checks++; if (fwd_a1 !== 2'b01) begin errors++; $display("FAIL r0_rw_fwd: got %b expected 01", fwd_a1); end
        cyc();
        checks++; if (wb_wr_en0 !== 1'b0 || wb_wr_en1 !== 1'b1) begin errors++; $display("FAIL r0_wb_en: got ro=%b rw=%b expected 0/1", wb_wr_en0, wb_wr_en1); end
        do_reset();
        set_id(1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        #1;
        checks++; if (stall0 !== 1'b0 || stall1 !== 1'b1) begin errors++; $display("FAIL r0_stall: got ro=%b rw=%b expected 0/1", stall0, stall1); end
    endtask

    task automatic test_flush;
        do_reset();
        set_id(1'b1, 3'd4, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 3'd1, 1'b1, 1'b0, 3'd4, 3'd0, 1'b1, 1'b0);
        flush = 1'b1; #1;
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL fl_stall: got %b expected 1", stall0); end
        cyc(); flush = 1'b0; idle(); #1;
        checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL fl_cnt: got %0d expected 1", cnt0); end
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL fl_nostall: got %b expected 0", stall0); end
        cyc();
        checks++; if (wb_dest0 !== 3'd4 || wb_wr_en0 !== 1'b1) begin errors++; $display("FAIL fl_load_wb: got dest=%0d en=%b expected 4/1", wb_dest0, wb_wr_en0); end
        cyc();
        checks++; if (wb_wr_en0 !== 1'b0) begin errors++; $display("FAIL fl_bubble_wb: got %b expected 0", wb_wr_en0); end
        do_reset();
        set_id(1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        flush = 1'b1;
        cyc(); flush = 1'b0; idle();
        cyc(); cyc();
        checks++; if (wb_wr_en0 !== 1'b0) begin errors++; $display("FAIL fl_only_wb: got %b expected 0", wb_wr_en0); end
    endtask

    task automatic test_saturation;
        do_reset();
        set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 28; i++) cyc();
        checks++; if (cnt1 !== 4'hE) begin errors++; $display("FAIL sat_pre: got %h expected e", cnt1); end
        for (int i = 0; i < 12; i++) cyc();
        checks++; if (cnt1 !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h expected f", cnt1); end
        checks++; if (cnt0 !== 16'd20) begin errors++; $display("FAIL sat_wide_cnt: got %0d expected 20", cnt0); end
    endtask

    task automatic test_reset_midflight;
        set_id(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 3'd3, 1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0);
        cyc(); idle(); #1;
        checks++; if (fwd_a0 !== 2'b01 || wb_wr_en0 !== 1'b1 || wb_dest0 !== 3'd1) begin
            errors++; $display("FAIL mid_pre: got fwd_a=%b en=%b dest=%0d expected 01/1/1", fwd_a0, wb_wr_en0, wb_dest0);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0; #1;
        checks++; if (wb_wr_en0 !== 1'b0 || stall0 !== 1'b0) begin errors++; $display("FAIL mid_wb_stall: got en=%b stall=%b expected 0/0", wb_wr_en0, stall0); end
        checks++; if ({fwd_a0, fwd_b0} !== 4'b0000) begin errors++; $display("FAIL mid_fwd: got %b expected 0000", {fwd_a0, fwd_b0}); end
        checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", cnt0); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (wb_wr_en0 !== 1'b0) begin errors++; $display("FAIL mid_stale_%0d: got %b expected 0", i, wb_wr_en0); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance2(1'b1, 2'b01);
        test_distance2(1'b0, 2'b10);
        test_load_use();
        test_reg0();
        test_flush();
        test_saturation();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
